// File: rtl/dram_responder_if.sv
// dram_responder_if: CPU data-port request/response bundle between core (master) and responder (slave).
interface dram_responder_if;
  logic        dram_en;
  logic        dram_wen;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [3:0]  dram_wmask;
  logic        dram_ready;
  logic        dram_rvalid;
  logic [31:0] dram_rdata;
  logic        dram_err;
  modport master (
    output dram_en, dram_wen, dram_addr, dram_wdata, dram_wmask,
    input  dram_ready, dram_rvalid, dram_rdata, dram_err
  );
  modport slave (
    input  dram_en, dram_wen, dram_addr, dram_wdata, dram_wmask,
    output dram_ready, dram_rvalid, dram_rdata, dram_err
  );
endinterface

// File: rtl/dram_responder.sv
// dram_responder: wait-stated word RAM with byte-lane stores; DRAM_RESP_ERR_EN enables the address-window check.
module dram_responder #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  dram_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  wen_q, inr_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wmask_q;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic                  accept, go, inr_i, a_wen, a_inr;
  logic [ADDR_WIDTH-1:0] idx_i, a_idx;
  logic [31:0]           a_wdata;
  logic [3:0]            a_wmask;
  logic                  unused;
  assign idx_i  = bus.dram_addr[ADDR_WIDTH+1:2];
  assign unused = ^{bus.dram_addr[31:ADDR_WIDTH+2], bus.dram_addr[1:0]};
`ifdef DRAM_RESP_ERR_EN
  assign inr_i = bus.dram_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
`else
  assign inr_i = 1'b1;
`endif
  assign bus.dram_ready  = state_q == IDLE;
  assign bus.dram_rvalid = state_q == RESP;
  assign bus.dram_rdata  = rdata_q;
  assign bus.dram_err    = err_q;
  // With zero wait states the access happens on the accept edge, so use live inputs then.
  always_comb begin
    accept  = state_q == IDLE && bus.dram_en;
    a_wen   = state_q == IDLE ? bus.dram_wen   : wen_q;
    a_inr   = state_q == IDLE ? inr_i          : inr_q;
    a_idx   = state_q == IDLE ? idx_i          : idx_q;
    a_wdata = state_q == IDLE ? bus.dram_wdata : wdata_q;
    a_wmask = state_q == IDLE ? bus.dram_wmask : wmask_q;
    state_d = state_q == IDLE ? (bus.dram_en ? (WC == 4'd0 ? RESP : WAIT) : IDLE)
            : state_q == WAIT ? (cnt_q == 4'd1 ? RESP : WAIT) : IDLE;
    cnt_d   = accept ? WC : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    go      = state_d == RESP;
    rdata_d = go ? (a_inr && !a_wen ? mem[a_idx] : 32'd0) : rdata_q;
    err_d   = go ? !a_inr : err_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
    if (accept) begin
      wen_q   <= bus.dram_wen;
      inr_q   <= inr_i;
      idx_q   <= idx_i;
      wdata_q <= bus.dram_wdata;
      wmask_q <= bus.dram_wmask;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && go && a_wen && a_inr)
      for (int i = 0; i < 4; i++)
        if (a_wmask[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: vector table, reset/throughput sequences and a random run against a word-map model.
module tb_dram_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  dram_responder_if b0 ();
  dram_responder_if b1 ();
  dram_responder_if b3 ();
  dram_responder #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  dram_responder #(.WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  dram_responder #(.WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  always #5 clk = ~clk;
  typedef struct {
    logic        w;
    logic [31:0] a, d;
    logic [3:0]  m;
    logic [31:0] rd;
    logic        er;
  } vec_t;
  vec_t vt[$];
  logic [31:0] model [int];
  int acc0[$], rv0[$], acc3[$], rv3[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic void add(input logic w, input logic [31:0] a, d, input logic [3:0] m,
                              input logic [31:0] rd, input logic er);
    vt.push_back('{w, a, d, m, rd, er});
  endfunction
  function automatic bit in_range(input logic [31:0] a);
`ifdef DRAM_RESP_ERR_EN
    return a[31:14] == 18'h20000;
`else
    return a[31] | 1'b1;
`endif
  endfunction
  task automatic acc(input logic w, input logic [31:0] a, d, input logic [3:0] m,
                     output logic [31:0] rd, output logic er);
    int n = 0;
    @(negedge clk);
    while (!b1.dram_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_before_req", 32'(b1.dram_ready), 32'd1);
    b1.dram_en = 1'b1; b1.dram_wen = w; b1.dram_addr = a; b1.dram_wdata = d; b1.dram_wmask = m;
    @(posedge clk); #1;
    b1.dram_en = 1'b0; b1.dram_wen = ~w; b1.dram_addr = $urandom; b1.dram_wdata = $urandom; b1.dram_wmask = 4'hF;
    n = 0;
    do begin @(negedge clk); n++; end while (!b1.dram_rvalid && n < 20);
    chk("latency", 32'(n), 32'd2);
    rd = b1.dram_rdata;
    er = b1.dram_err;
    @(negedge clk);
    chk("rvalid_one_cycle", 32'(b1.dram_rvalid), 32'd0);
  endtask
  initial begin
    logic [31:0] rd, a, d, exp_rd, tmp;
    logic        er, w;
    logic [3:0]  m;
    int          idx, nrv;
    b0.dram_en = 0; b0.dram_wen = 0; b0.dram_addr = 32'h8000_0000; b0.dram_wdata = 0; b0.dram_wmask = 0;
    b1.dram_en = 0; b1.dram_wen = 0; b1.dram_addr = 0;             b1.dram_wdata = 0; b1.dram_wmask = 0;
    b3.dram_en = 0; b3.dram_wen = 0; b3.dram_addr = 32'h8000_0004; b3.dram_wdata = 0; b3.dram_wmask = 0;
    add(1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
    add(0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0);
    add(1, 32'h8000_0010, 32'h00AA_0000, 4'h4, 32'h0, 0);
    add(0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAA_BEEF, 0);
    add(1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 0);
    add(0, 32'h8000_0013, 32'h0,         4'h0, 32'hDEAA_BEEF, 0);
    add(1, 32'h8000_0020, 32'h1234_5678, 4'hF, 32'h0, 0);
    add(0, 32'h8000_0020, 32'h0,         4'h0, 32'h1234_5678, 0);
    add(1, 32'h8000_0024, 32'h1122_3344, 4'hF, 32'h0, 0);
    add(1, 32'h8000_0024, 32'hAABB_CCDD, 4'h9, 32'h0, 0);
    add(0, 32'h8000_0024, 32'h0,         4'h0, 32'hAA22_33DD, 0);
`ifdef DRAM_RESP_ERR_EN
    add(0, 32'h0000_1000, 32'h0,         4'h0, 32'h0, 1);
    add(1, 32'h0000_0010, 32'h5555_5555, 4'hF, 32'h0, 1);
    add(0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAA_BEEF, 0);
`else
    add(1, 32'h0000_0010, 32'h5555_5555, 4'hF, 32'h0, 0);
    add(0, 32'h8000_0010, 32'h0,         4'h0, 32'h5555_5555, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_ready", 32'(b1.dram_ready), 32'd1);
    chk("rst_rvalid", 32'(b1.dram_rvalid), 32'd0);
    chk("rst_rdata", b1.dram_rdata, 32'd0);
    chk("rst_err", 32'(b1.dram_err), 32'd0);
    foreach (vt[i]) begin
      acc(vt[i].w, vt[i].a, vt[i].d, vt[i].m, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].er));
    end
    // Reset while the store waits: it must never commit or respond.
    @(negedge clk);
    b1.dram_en = 1; b1.dram_wen = 1; b1.dram_addr = 32'h8000_0020; b1.dram_wdata = 32'h0BAD_F00D; b1.dram_wmask = 4'hF;
    @(posedge clk); #1;
    b1.dram_en = 0;
    rst = 1'b0;
    nrv = 0;
    @(negedge clk); nrv += int'(b1.dram_rvalid);
    @(negedge clk); nrv += int'(b1.dram_rvalid);
    rst = 1'b1;
    repeat (4) begin @(negedge clk); nrv += int'(b1.dram_rvalid); end
    chk("midrst_no_rvalid", 32'(nrv), 32'd0);
    acc(0, 32'h8000_0020, 0, 0, rd, er);
    chk("midrst_unchanged", rd, 32'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      acc(1, 32'h8000_0100 + 32'(4 * i), d, 4'hF, rd, er);
      model[64 + i] = d;
    end
    for (int k = 0; k < 60; k++) begin
      a = 32'h8000_0100 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) a = a ^ 32'h4000_0000;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      idx = int'(a[13:2]);
      exp_rd = (!w && in_range(a)) ? model[idx] : 32'd0;
      acc(w, a, d, m, rd, er);
      chk($sformatf("rnd%0d_rdata", k), rd, exp_rd);
      chk($sformatf("rnd%0d_err", k), 32'(er), 32'(!in_range(a)));
      if (w && in_range(a)) begin
        tmp = model[idx];
        for (int b = 0; b < 4; b++) if (m[b]) tmp[8*b +: 8] = d[8*b +: 8];
        model[idx] = tmp;
      end
    end
    @(negedge clk);
    b0.dram_en = 1; b3.dram_en = 1;
    for (int c = 0; c < 60; c++) begin
      if (c == 40) begin b0.dram_en = 0; b3.dram_en = 0; end
      if (b0.dram_en && b0.dram_ready) acc0.push_back(c);
      if (b0.dram_rvalid) rv0.push_back(c);
      if (b3.dram_en && b3.dram_ready) acc3.push_back(c);
      if (b3.dram_rvalid) rv3.push_back(c);
      @(negedge clk);
    end
    chk("w0_accepts", 32'(acc0.size()), 32'd20);
    chk("w0_responses", 32'(rv0.size()), 32'(acc0.size()));
    chk("w3_accepts", 32'(acc3.size()), 32'd8);
    chk("w3_responses", 32'(rv3.size()), 32'(acc3.size()));
    for (int i = 0; i < acc0.size() && i < rv0.size(); i++) begin
      chk($sformatf("w0_lat%0d", i), 32'(rv0[i] - acc0[i]), 32'd1);
      if (i > 0) chk($sformatf("w0_gap%0d", i), 32'(acc0[i] - acc0[i-1]), 32'd2);
    end
    for (int i = 0; i < acc3.size() && i < rv3.size(); i++) begin
      chk($sformatf("w3_lat%0d", i), 32'(rv3[i] - acc3[i]), 32'd4);
      if (i > 0) chk($sformatf("w3_gap%0d", i), 32'(acc3[i] - acc3[i-1]), 32'd5);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
